// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending write-back counters that gate decode issue.
// Optional stall statistics counter is built only when SCOREBOARD_STATS_EN is defined.
module reg_scoreboard #(
    parameter int ADDR_LEN    = 5,
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issueValid,
    input  logic [ADDR_LEN-1:0] issueSrc1,
    input  logic [ADDR_LEN-1:0] issueSrc2,
    input  logic                issueUsesSrc1,
    input  logic                issueUsesSrc2,
    input  logic [ADDR_LEN-1:0] issueDest,
    input  logic                issueWritesDest,
    output logic                issueReady,
    input  logic                wbEn,
    input  logic [ADDR_LEN-1:0] wbDest,
    input  logic                killEn,
    input  logic [ADDR_LEN-1:0] killDest,
    output logic [NUM_REGS-1:0] busyMask,
    output logic                underflow,
    output logic [15:0]         stallCount
);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    eff   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                uf_q, uf_d;
    logic                uf_hit;
    logic [CNT_W:0]      rel, diff;
    logic                haz_src1, haz_src2, haz_dest, fire, acq;

    // Releases landing this cycle already count as done: eff is the post-release count.
    always_comb begin
        uf_hit = 1'b0;
        rel    = '0;
        diff   = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            rel  = {{CNT_W{1'b0}}, (wbEn && (wbDest == ADDR_LEN'(r)))}
                 + {{CNT_W{1'b0}}, (killEn && (killDest == ADDR_LEN'(r)))};
            diff = {1'b0, cnt_q[r]} - rel;
            if (r == 0) begin
                eff[r] = '0;
            end else if (rel > {1'b0, cnt_q[r]}) begin
                eff[r] = '0;
                uf_hit = 1'b1;
            end else begin
                eff[r] = diff[CNT_W-1:0];
            end
        end
    end

    assign haz_src1   = issueUsesSrc1 && (issueSrc1 != '0) && (eff[issueSrc1] != '0);
    assign haz_src2   = issueUsesSrc2 && (issueSrc2 != '0) && (eff[issueSrc2] != '0);
    assign haz_dest   = issueWritesDest && (issueDest != '0)
                     && (eff[issueDest] == CNT_W'(MAX_PENDING));
    assign issueReady = !(haz_src1 || haz_src2 || haz_dest);
    assign fire       = issueValid && issueReady;

    always_comb begin
        acq    = 1'b0;
        busy_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            acq       = fire && issueWritesDest && (issueDest == ADDR_LEN'(r)) && (r != 0);
            cnt_d[r]  = eff[r] + CNT_W'(acq);
            busy_d[r] = (cnt_d[r] != '0);
        end
        uf_d = uf_q || uf_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
            uf_q   <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
            uf_q   <= uf_d;
        end
    end

    assign busyMask  = busy_q;
    assign underflow = uf_q;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (issueValid && !issueReady && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stallCount = stall_q;
`else
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues expected outputs, a negedge monitor checks them.
module tb_reg_scoreboard;

    localparam int AL = 5;
    localparam int NR = 32;
`ifdef SCOREBOARD_STATS_EN
    localparam logic [31:0] STALL_EXP = 32'd4;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          issueValid, issueUsesSrc1, issueUsesSrc2, issueWritesDest;
    logic [AL-1:0] issueSrc1, issueSrc2, issueDest;
    logic          issueReady;
    logic          wbEn, killEn;
    logic [AL-1:0] wbDest, killDest;
    logic [NR-1:0] busyMask;
    logic          underflow;
    logic [15:0]   stallCount;

    always #5 clk = ~clk;

    reg_scoreboard #(.ADDR_LEN(AL), .NUM_REGS(NR), .MAX_PENDING(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issueValid(issueValid), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
        .issueUsesSrc1(issueUsesSrc1), .issueUsesSrc2(issueUsesSrc2),
        .issueDest(issueDest), .issueWritesDest(issueWritesDest), .issueReady(issueReady),
        .wbEn(wbEn), .wbDest(wbDest), .killEn(killEn), .killDest(killDest),
        .busyMask(busyMask), .underflow(underflow), .stallCount(stallCount)
    );

    typedef enum int {S_READY, S_BUSY, S_UF, S_STALL} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic expect_out(input string name, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        q.push_back(e);
    endtask

    function automatic logic [31:0] pick(input sel_t sel);
        case (sel)
            S_READY: return {31'd0, issueReady};
            S_BUSY:  return busyMask;
            S_UF:    return {31'd0, underflow};
            default: return {16'd0, stallCount};
        endcase
    endfunction

    // Monitor: all expectations queued for a cycle are checked on its falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                e   = q.pop_front();
                act = pick(e.sel);
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic idle();
        issueValid = 0; issueUsesSrc1 = 0; issueUsesSrc2 = 0; issueWritesDest = 0;
        issueSrc1 = '0; issueSrc2 = '0; issueDest = '0;
        wbEn = 0; wbDest = '0; killEn = 0; killDest = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic writer(input logic [AL-1:0] d);
        issueValid = 1; issueWritesDest = 1; issueDest = d;
    endtask

    task automatic reader1(input logic [AL-1:0] s);
        issueValid = 1; issueUsesSrc1 = 1; issueSrc1 = s;
    endtask

    initial begin
        rst = 0;
        idle();
        issueUsesSrc1 = 1; issueSrc1 = 5'd5;
        expect_out("rst_ready", S_READY, 1);
        expect_out("rst_busy", S_BUSY, 0);
        expect_out("rst_uf", S_UF, 0);
        expect_out("rst_stall", S_STALL, 0);

        next(); rst = 1;
        writer(5);                        expect_out("w5_ready", S_READY, 1);
        next(); reader1(5);               expect_out("raw5_stall", S_READY, 0);
                                          expect_out("raw5_busy", S_BUSY, 32'h20);
        next(); reader1(5); wbEn = 1; wbDest = 5;
                                          expect_out("raw5_bypass", S_READY, 1);
        next();                           expect_out("r5_released", S_BUSY, 0);

        writer(7);                        expect_out("w7a", S_READY, 1);
        next(); writer(7);                expect_out("w7b", S_READY, 1);
                                          expect_out("w7b_busy", S_BUSY, 32'h80);
        next(); writer(7);                expect_out("w7c", S_READY, 1);
        next(); writer(7);                expect_out("w7_full", S_READY, 0);
        next(); writer(7); wbEn = 1; wbDest = 7;
                                          expect_out("w7_full_rel", S_READY, 1);
        next(); writer(7);                expect_out("w7_still3", S_READY, 0);
        next(); wbEn = 1; wbDest = 7;
        next(); wbEn = 1; wbDest = 7;
        next(); wbEn = 1; wbDest = 7;
        next();                           expect_out("r7_drained", S_BUSY, 0);

        reader1(0); issueWritesDest = 1;  expect_out("r0_ready", S_READY, 1);
        next(); reader1(0); wbEn = 1; wbDest = 0;
                                          expect_out("r0_wb_ready", S_READY, 1);
        next(); writer(9);                expect_out("r0_no_uf", S_UF, 0);
                                          expect_out("r0_busy", S_BUSY, 0);
        next(); issueValid = 1; issueUsesSrc2 = 1; issueSrc2 = 9;
                                          expect_out("src2_stall", S_READY, 0);
                                          expect_out("src2_busy", S_BUSY, 32'h200);
        next(); issueValid = 1; issueSrc2 = 9;
        wbEn = 1; wbDest = 9; killEn = 1; killDest = 9;
                                          expect_out("src2_unused", S_READY, 1);
        next();                           expect_out("uf_set", S_UF, 1);
                                          expect_out("uf_busy", S_BUSY, 0);
                                          expect_out("stall_count", S_STALL, STALL_EXP);
        next();                           expect_out("uf_sticky", S_UF, 1);

        writer(3);
        next(); writer(3);
        next(); issueUsesSrc1 = 1; issueSrc1 = 3;
                                          expect_out("r3_pending", S_READY, 0);
                                          expect_out("r3_busy", S_BUSY, 32'h8);
        @(posedge clk);
        #2;
        rst = 0;
        expect_out("async_busy", S_BUSY, 0);
        expect_out("async_ready", S_READY, 1);
        expect_out("async_uf", S_UF, 0);
        expect_out("async_stall", S_STALL, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard sitting directly upstream of the register file's read ports in the decode stage. It tracks, per architectural register, how many issued instructions still owe a write-back, and holds decode (`issueReady` low) while a source operand is pending. It consumes the same `writeEn`/`dest` pair that drives the register file write port, so a register is released in the cycle its value lands.

## Interface
Parameters:
- `ADDR_LEN`, 5, register address width (matches register-file address length)
- `NUM_REGS`, 32, number of architectural registers
- `MAX_PENDING`, 3, max in-flight writes per register (pipeline depth after decode)
- `CNT_W`, 2, pending-counter width; must hold `MAX_PENDING`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `issueValid`  in  1  decode presents an instruction
- `issueSrc1`, `issueSrc2`  in  ADDR_LEN  source register addresses
- `issueUsesSrc1`, `issueUsesSrc2`  in  1  instruction actually reads that source
- `issueDest`  in  ADDR_LEN  destination register
- `issueWritesDest`  in  1  instruction writes `issueDest`
- `issueReady`  out  1  combinational; instruction may advance this cycle
- `wbEn`  in  1  write-back strobe (same signal as register-file write enable)
- `wbDest`  in  ADDR_LEN  write-back destination
- `killEn`  in  1  an in-flight writer was squashed and will never write back
- `killDest`  in  ADDR_LEN  destination of the squashed writer
- `busyMask`  out  NUM_REGS  registered; bit r = pending count of r nonzero
- `underflow`  out  1  sticky; a release hit a zero count
- `stallCount`  out  16  saturating stall-cycle counter (only with `SCOREBOARD_STATS_EN`)

## Operation
- State: one `CNT_W`-bit counter `cnt[r]` per register r = 1..NUM_REGS-1; r0 has no counter, reads as 0, never busy.
- `rel[r]` = (`wbEn` && `wbDest`==r) + (`killEn` && `killDest`==r), range 0..2.
- Effective count `eff[r]` = max(`cnt[r]` - `rel[r]`, 0). A release counts as done in its own cycle, because the register file writes on the falling edge before decode samples it.
- `issueReady` = 1 unless any of:
  - `issueUsesSrc1` && `issueSrc1`≠0 && `eff[issueSrc1]`≠0
  - `issueUsesSrc2` && `issueSrc2`≠0 && `eff[issueSrc2]`≠0
  - `issueWritesDest` && `issueDest`≠0 && `eff[issueDest]`==`MAX_PENDING` (structural)
- `issueReady` is independent of `issueValid`. Fire = `issueValid` && `issueReady`.
- `acq[r]` = fire && `issueWritesDest` && `issueDest`==r && r≠0.
- Next state: `cnt[r]` <= `eff[r]` + `acq[r]`. Issue and release on the same register in the same cycle nets correctly, e.g. 1 - 1 + 1 = 1.
- If `rel[r]` > `cnt[r]`: count floors at 0 and `underflow` is set. It stays set until reset.
- Release to r0 is ignored and never flags.
- `busyMask[r]` <= (next `cnt[r]` ≠ 0); bit 0 is always 0.

## Timing
- Reset (async, `rst`=0): all `cnt` 0, `busyMask` 0, `underflow` 0, `stallCount` 0. `issueReady` then follows its combinational rule (1 for any valid request).
- Reset mid-operation discards all pending state immediately; the pipeline flush is the owner's responsibility.
- `issueReady` has zero latency from inputs and current state.
- Counter and `busyMask` update one rising edge after fire/release.
- A dependent instruction held by a pending write advances in the same cycle the matching `wbEn` arrives (0-cycle release).
- No handshake on `wbEn`/`killEn`; they are always accepted.

## Configuration
- `SCOREBOARD_STATS_EN` defined: `stallCount` increments each cycle `issueValid` && !`issueReady` and saturates at 16'hFFFF.
- Not defined: `stallCount` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then issue writer dest=5; next cycle issue reader src1=5 -> `issueReady`=0, `busyMask[5]`=1. Assert `wbEn`, `wbDest`=5 -> `issueReady`=1 that cycle; `busyMask[5]`=0 after the edge.
- Three writers to r7 back-to-back -> `cnt[7]`=3; a fourth writer to r7 -> `issueReady`=0. Same cycle with `wbEn`,`wbDest`=7 -> fourth issues and `cnt[7]` stays 3.
- Writer dest=0 and reader src1=0 -> always `issueReady`=1, `busyMask`=0. `wbEn`,`wbDest`=0 -> `underflow` stays 0.
- `cnt[9]`=1, `wbEn` and `killEn` both to r9 in the same cycle -> `cnt[9]`=0 and `underflow`=1, held until reset.
- Drop `rst` while `cnt[3]`=2 -> `busyMask`=0 without waiting for a clock; a reader of r3 sees `issueReady`=1.
- With `SCOREBOARD_STATS_EN`: 4 stalled cycles -> `stallCount`=4. Without it -> `stallCount`=0.
